mem_bus_master: RTL and testbench

- Initiator side of the 32x8 tri-state scratch memory bus (addr/rd/wr/inout data) in the Simple RISC CPU.
- Accepts single read or write requests from the CPU core over a valid/ready handshake.
- Sequences the memory-bus strobes, owns the bidirectional data line, and enforces bus turnaround.
- Returns one response per request.

---
 rtl/mem_bus_master.sv | 152 +++++++++++++++
 tb/tb_mem_bus_master.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - Initiator for the tri-state scratch memory bus (addr/rd/wr/inout data).
// Optional macro MEM_BUS_MASTER_WRITE_VERIFY_EN adds a readback check after every write.
module mem_bus_master #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  inout  wire  [DATA_W-1:0] mem_data
);

`ifdef MEM_BUS_MASTER_WRITE_VERIFY_EN
  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_TURN, S_VERIFY} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_TURN} state_t;
`endif

  localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   wdata_q;
  logic                mem_oe;
  logic                accept;
  logic                rsp_set;
  logic                capture;

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign mem_data  = mem_oe ? wdata_q : {DATA_W{1'bz}};

`ifdef MEM_BUS_MASTER_WRITE_VERIFY_EN
  logic verify_pend_q, verify_pend_d;
  logic err_d;
`else
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rsp_set = 1'b0;
    capture = 1'b0;
`ifdef MEM_BUS_MASTER_WRITE_VERIFY_EN
    verify_pend_d = verify_pend_q;
    err_d         = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = req_we ? S_WRITE : S_READ;
      end
      S_READ: begin
        state_d = S_TURN;
        cnt_d   = TURN_LOAD;
        rsp_set = 1'b1;
        capture = 1'b1;
      end
      S_WRITE: begin
        state_d = S_TURN;
        cnt_d   = TURN_LOAD;
`ifdef MEM_BUS_MASTER_WRITE_VERIFY_EN
        verify_pend_d = 1'b1;
`else
        rsp_set = 1'b1;
`endif
      end
      S_TURN: begin
        if (cnt_q == 4'd0) begin
`ifdef MEM_BUS_MASTER_WRITE_VERIFY_EN
          if (verify_pend_q) begin
            state_d       = S_VERIFY;
            verify_pend_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
`else
          state_d = S_IDLE;
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`ifdef MEM_BUS_MASTER_WRITE_VERIFY_EN
      S_VERIFY: begin
        state_d = S_TURN;
        cnt_d   = TURN_LOAD;
        rsp_set = 1'b1;
        capture = 1'b1;
        err_d   = (mem_data != wdata_q);
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes and driver enable are registered from the next state, so the
  // bus pins never see a combinational path from the request side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      wdata_q   <= '0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_oe    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rsp_valid <= rsp_set;
      if (accept) begin
        mem_addr <= req_addr;
        wdata_q  <= req_wdata;
      end
      if (capture) rsp_rdata <= mem_data;
`ifdef MEM_BUS_MASTER_WRITE_VERIFY_EN
      mem_rd <= (state_d == S_READ) || (state_d == S_VERIFY);
`else
      mem_rd <= (state_d == S_READ);
`endif
      mem_wr <= (state_d == S_WRITE);
      mem_oe <= (state_d == S_WRITE);
    end
  end

`ifdef MEM_BUS_MASTER_WRITE_VERIFY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      verify_pend_q <= 1'b0;
      rsp_err       <= 1'b0;
    end else begin
      verify_pend_q <= verify_pend_d;
      if (rsp_set) rsp_err <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_bus_master.sv
// tb/tb_mem_bus_master.sv - Scoreboard bench for mem_bus_master with TURN_CYCLES=1 and =3 instances.
module tb_mem_bus_master;
  localparam int AW = 5;
  localparam int DW = 8;
`ifdef MEM_BUS_MASTER_WRITE_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] rd;
    logic          err;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid [2];
  logic          req_ready [2];
  logic          req_we    [2];
  logic [AW-1:0] req_addr  [2];
  logic [DW-1:0] req_wdata [2];
  logic          rsp_valid [2];
  logic [DW-1:0] rsp_rdata [2];
  logic          rsp_err   [2];
  logic [AW-1:0] mem_addr  [2];
  logic          mem_rd    [2];
  logic          mem_wr    [2];
  logic [DW-1:0] stuck = '0;
  logic [DW-1:0] last_rd [2];
  int            last_acc [2];
  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  exp_t          q0[$];
  exp_t          q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int tc(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic void check(bit ok, string name, longint act, longint exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_inst
    wire  [DW-1:0] mem_data;
    logic [DW-1:0] mem [32];
    logic          prev_rd = 1'b0;

    mem_bus_master #(.ADDR_W(AW), .DATA_W(DW), .TURN_CYCLES((g == 0) ? 1 : 3)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
      .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g]),
      .mem_addr(mem_addr[g]), .mem_rd(mem_rd[g]), .mem_wr(mem_wr[g]), .mem_data(mem_data)
    );

    assign mem_data = mem_rd[g] ? (mem[mem_addr[g]] | stuck) : {DW{1'bz}};

    always @(posedge clk) begin
      if (cyc == 0) begin
        for (int i = 0; i < 32; i++) mem[i] <= 8'hEE;
      end else if (mem_wr[g]) begin
        mem[mem_addr[g]] <= mem_data;
      end
    end

    always @(negedge clk) begin : mon
      exp_t e;
      if (rsp_valid[g]) begin
        if ((g == 0 ? q0.size() : q1.size()) == 0) begin
          check(1'b0, $sformatf("unexpected_rsp[%0d]", g), 1, 0);
        end else begin
          if (g == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          check(rsp_rdata[g] == e.rd, $sformatf("rsp_rdata[%0d]", g), rsp_rdata[g], e.rd);
          check(rsp_err[g] == e.err, $sformatf("rsp_err[%0d]", g), rsp_err[g], e.err);
          check(cyc == e.due, $sformatf("rsp_cycle[%0d]", g), cyc, e.due);
        end
      end
      if (mem_rd[g] || mem_wr[g] || dut.mem_oe)
        check(!(mem_rd[g] && mem_wr[g]), $sformatf("rd_wr_both[%0d]", g), 1, 0);
      if (dut.mem_oe)
        check(!mem_rd[g] && !prev_rd && !$isunknown(mem_data),
              $sformatf("turnaround[%0d]", g), {mem_rd[g], prev_rd}, 0);
      prev_rd <= mem_rd[g];
    end
  end

  task automatic push(int k, exp_t e);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic do_req(int k, bit we, logic [AW-1:0] addr, logic [DW-1:0] wd,
                        logic [DW-1:0] exp_rd, bit exp_err, bit noise, bit track, bit chk_gap);
    int   t = 0;
    int   acc;
    exp_t e;
    @(negedge clk);
    req_valid[k] = 1'b1;
    req_we[k] = we; req_addr[k] = addr; req_wdata[k] = wd;
    while (!req_ready[k]) begin
      if (noise) begin
        req_we[k] = 1'($urandom); req_addr[k] = AW'($urandom); req_wdata[k] = DW'($urandom);
      end
      @(negedge clk);
      t++;
      if (t > 50) begin
        check(1'b0, "ready_timeout", 0, 1);
        req_valid[k] = 1'b0;
        return;
      end
    end
    req_we[k] = we; req_addr[k] = addr; req_wdata[k] = wd;
    acc = cyc + 1;
    if (chk_gap) check(acc - last_acc[k] == 2 + tc(k), "accept_gap", acc - last_acc[k], 2 + tc(k));
    last_acc[k] = acc;
    if (track) begin
      e.rd  = (we && !VERIFY) ? last_rd[k] : exp_rd;
      e.err = (we && VERIFY) ? exp_err : 1'b0;
      e.due = acc + ((we && VERIFY) ? 2 + tc(k) : 1);
      last_rd[k] = e.rd;
      push(k, e);
    end
    @(posedge clk);
    #1 req_valid[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 0; req_we[k] = 0; req_addr[k] = '0; req_wdata[k] = '0;
      last_rd[k] = '0; last_acc[k] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check(req_ready[k] == 1'b1, "rst_req_ready", req_ready[k], 1);
      check(rsp_valid[k] == 1'b0, "rst_rsp_valid", rsp_valid[k], 0);
      check(rsp_rdata[k] == '0, "rst_rsp_rdata", rsp_rdata[k], 0);
      check(rsp_err[k] == 1'b0, "rst_rsp_err", rsp_err[k], 0);
      check(mem_addr[k] == '0, "rst_mem_addr", mem_addr[k], 0);
      check(mem_rd[k] == 1'b0, "rst_mem_rd", mem_rd[k], 0);
      check(mem_wr[k] == 1'b0, "rst_mem_wr", mem_wr[k], 0);
    end
    check(gen_inst[0].dut.mem_oe == 1'b0, "rst_mem_oe", gen_inst[0].dut.mem_oe, 0);
    rst_n = 1'b1;

    // Reset lands in the middle of a write, before its write edge.
    do_req(0, 1'b1, 5'h07, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check(mem_wr[0] == 1'b1, "pre_reset_mem_wr", mem_wr[0], 1);
    rst_n = 1'b0;
    #1;
    check(mem_wr[0] == 1'b0, "async_rst_mem_wr", mem_wr[0], 0);
    check(gen_inst[0].dut.mem_oe == 1'b0, "async_rst_mem_oe", gen_inst[0].dut.mem_oe, 0);
    check(req_ready[0] == 1'b1, "async_rst_req_ready", req_ready[0], 1);
    check(rsp_valid[0] == 1'b0, "async_rst_rsp_valid", rsp_valid[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check(gen_inst[0].mem[7] == 8'hEE, "aborted_write_mem", gen_inst[0].mem[7], 8'hEE);
    last_rd[0] = '0;

    do_req(0, 1'b1, 5'h03, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    do_req(0, 1'b0, 5'h03, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1);

    for (int a = 0; a < 32; a++)
      do_req(0, 1'b1, AW'(a), DW'(a) ^ 8'h5A, DW'(a) ^ 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int a = 0; a < 32; a++)
      do_req(0, 1'b0, AW'(a), 8'h00, DW'(a) ^ 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);

    do_req(0, 1'b0, 5'h05, 8'h00, 8'h5F, 1'b0, 1'b1, 1'b1, 1'b1);
    do_req(0, 1'b1, 5'h09, 8'h77, 8'h77, 1'b0, 1'b1, 1'b1, 1'b1);
    do_req(0, 1'b0, 5'h09, 8'h00, 8'h77, 1'b0, 1'b1, 1'b1, 1'b1);
    do_req(0, 1'b0, 5'h04, 8'h00, 8'h5E, 1'b0, 1'b1, 1'b1, 1'b1);

    // TURN_CYCLES=3 instance: reads immediately followed by writes.
    for (int i = 0; i < 4; i++) begin
      do_req(1, 1'b0, AW'(i), 8'h00, 8'hEE, 1'b0, 1'b0, 1'b1, i > 0);
      do_req(1, 1'b1, AW'(i), 8'h40 + DW'(i), 8'h40 + DW'(i), 1'b0, 1'b0, 1'b1, 1'b1);
    end
    for (int i = 0; i < 4; i++)
      do_req(1, 1'b0, AW'(i), 8'h00, 8'h40 + DW'(i), 1'b0, 1'b0, 1'b1, 1'b1);

`ifdef MEM_BUS_MASTER_WRITE_VERIFY_EN
    do_req(0, 1'b1, 5'h1F, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    stuck = 8'h01;
    do_req(0, 1'b1, 5'h1F, 8'h3C, 8'h3D, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    stuck = 8'h00;
`endif

    for (int t = 0; t < 20 && (q0.size() + q1.size()) != 0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    check(q0.size() == 0, "drain_q0", q0.size(), 0);
    check(q1.size() == 0, "drain_q1", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
